// File: rtl/partitioned_data_ram.sv
// Per-process partitioned data RAM with byte-enable writes, registered reads,
// range faulting, a self-zeroing sweep after reset and per-partition clear.
`timescale 1ns/1ps
module partitioned_data_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned PROC_COUNT = 4,
  parameter int unsigned PID_WIDTH  = 2,
  parameter int unsigned PROC_WORDS = 512
) (
  input  logic                    Clock,
  input  logic                    Reset_N,
  input  logic                    Req_Valid,
  output logic                    Req_Ready,
  input  logic                    Mem_Write,
  input  logic [DATA_WIDTH/8-1:0] Byte_Enable,
  input  logic [PID_WIDTH-1:0]    Process_ID,
  input  logic [ADDR_WIDTH-1:0]   Address,
  input  logic [DATA_WIDTH-1:0]   Write_Data,
  output logic [DATA_WIDTH-1:0]   Read_Data,
  output logic                    Read_Valid,
  output logic                    Fault,
  input  logic                    Clear_Req,
  input  logic [PID_WIDTH-1:0]    Clear_ID,
  output logic                    Clear_Done
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned OFF_WIDTH = $clog2(PROC_WORDS);
  localparam int unsigned DEPTH     = PROC_COUNT * PROC_WORDS;
  localparam int unsigned IDX_WIDTH = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_CLEAR = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PID_WIDTH-1:0]   clr_pid_q, clr_pid_d;
  logic                   ready_q, ready_d;
  logic [DATA_WIDTH-1:0]  read_data_q, read_data_d;
  logic                   read_valid_q, read_valid_d;
  logic                   fault_q, fault_d;
  logic                   clear_done_q, clear_done_d;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic                   mem_we_c;
  logic [IDX_WIDTH-1:0]   mem_idx_c;
  logic [DATA_WIDTH-1:0]  mem_wdata_c;
  logic [BE_WIDTH-1:0]    mem_be_c;

  logic                   acc_in_range_c;
  logic                   clr_in_range_c;
  logic [IDX_WIDTH-1:0]   acc_idx_c;
  logic [IDX_WIDTH-1:0]   clr_idx_c;

  assign acc_in_range_c = (64'(Address) < 64'(PROC_WORDS)) &&
                          (64'(Process_ID) < 64'(PROC_COUNT));
  assign clr_in_range_c = 64'(Clear_ID) < 64'(PROC_COUNT);
  assign acc_idx_c      = IDX_WIDTH'({Process_ID, Address[OFF_WIDTH-1:0]});
  assign clr_idx_c      = IDX_WIDTH'({clr_pid_q, cnt_q[OFF_WIDTH-1:0]});

  // State, sweep counter and registered outputs
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      clr_pid_q    <= '0;
      ready_q      <= 1'b0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clr_pid_q    <= clr_pid_d;
      ready_q      <= ready_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      fault_q      <= fault_d;
      clear_done_q <= clear_done_d;
    end
  end

  // Next-state, memory write port and output decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clr_pid_d    = clr_pid_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    fault_d      = 1'b0;
    clear_done_d = 1'b0;
    mem_we_c     = 1'b0;
    mem_idx_c    = '0;
    mem_wdata_c  = '0;
    mem_be_c     = '0;

    case (state_q)
      S_INIT: begin
        mem_we_c  = 1'b1;
        mem_idx_c = cnt_q;
        mem_be_c  = '1;
        if (cnt_q == IDX_WIDTH'(DEPTH - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_IDLE: begin
        if (Req_Valid) begin
          if (acc_in_range_c) begin
            if (Mem_Write) begin
              mem_we_c    = 1'b1;
              mem_idx_c   = acc_idx_c;
              mem_wdata_c = Write_Data;
              mem_be_c    = Byte_Enable;
            end else begin
              read_data_d  = mem_q[acc_idx_c];
              read_valid_d = 1'b1;
            end
          end else begin
            fault_d = 1'b1;
            if (!Mem_Write) begin
              read_data_d  = '0;
              read_valid_d = 1'b1;
            end
          end
        end
        // A same-cycle access has already been handled above; clear follows it
        if (Clear_Req) begin
          if (clr_in_range_c) begin
            state_d   = S_CLEAR;
            clr_pid_d = Clear_ID;
            cnt_d     = '0;
          end else begin
            fault_d = 1'b1;
          end
        end
      end

      S_CLEAR: begin
        mem_we_c  = 1'b1;
        mem_idx_c = clr_idx_c;
        mem_be_c  = '1;
        if (cnt_q[OFF_WIDTH-1:0] == OFF_WIDTH'(PROC_WORDS - 1)) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          clear_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // Byte-masked storage write, not reset
  always_ff @(posedge Clock) begin
    for (int b = 0; b < int'(BE_WIDTH); b++) begin
      if (mem_we_c && mem_be_c[b]) begin
        mem_q[mem_idx_c][8*b +: 8] <= mem_wdata_c[8*b +: 8];
      end
    end
  end

  assign Req_Ready  = ready_q;
  assign Read_Data  = read_data_q;
  assign Read_Valid = read_valid_q;
  assign Fault      = fault_q;
  assign Clear_Done = clear_done_q;

endmodule
